// File: rtl/forward_pkg.sv
// Shared constants, state encoding and saturating arithmetic for the forward grant controller.
package forward_pkg;

  localparam int unsigned ByteWDef      = 32;
  localparam int unsigned MaxPktByteDef = 1518;
  localparam int unsigned IdW           = 3;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StResp    = 3'd1;
  localparam state_t StBudget  = 3'd2;
  localparam state_t StWaitFin = 3'd3;
  localparam state_t StRelease = 3'd4;

  // Adds two w-bit values (carried in 64-bit containers), clamping at the w-bit all-ones value.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [63:0] max;
    max = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max}) begin
      return max;
    end
    return sum[63:0];
  endfunction

endpackage

// File: rtl/forward_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module forward_rr_arbiter
  import forward_pkg::*;
#(
  parameter int unsigned PORT_NUM = 4
) (
  input  logic [PORT_NUM-1:0] req_i,
  input  logic [IdW-1:0]      ptr_i,
  output logic [PORT_NUM-1:0] gnt_o,
  output logic [IdW-1:0]      idx_o,
  output logic                valid_o
);

  logic [7:0]   req_ext;
  logic [IdW:0] cand;

  always_comb begin
    req_ext = 8'(req_i);
    cand    = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < int'(PORT_NUM); i++) begin
      cand = {1'b0, ptr_i} + 4'(i);
      if (cand >= 4'(PORT_NUM)) begin
        cand = cand - 4'(PORT_NUM);
      end
      if (!valid_o && req_ext[cand[IdW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[IdW-1:0];
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int p = 0; p < int'(PORT_NUM); p++) begin
      if (valid_o && (idx_o == 3'(p))) begin
        gnt_o[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/forward_grant_ctrl.sv
// Forward request/response/finish responder: round-robin grant with cumulative byte budget.
// Optional forced release after TIMEOUT_CYC waiting cycles when FORWARD_TIMEOUT_EN is defined.
module forward_grant_ctrl
  import forward_pkg::*;
#(
  parameter int unsigned PORT_NUM     = 4,
  parameter int unsigned BYTE_W       = ByteWDef,
  parameter int unsigned MAX_PKT_BYTE = MaxPktByteDef,
  parameter int unsigned TIMEOUT_CYC  = 65535
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [PORT_NUM-1:0] i_forward_req,
  output logic [PORT_NUM-1:0] o_forward_resp,
  input  logic [PORT_NUM-1:0] i_forward_finish,
  output logic [BYTE_W-1:0]   o_forward_byte,
  output logic [PORT_NUM-1:0] o_forward_byte_valid,
  input  logic                i_slot_valid,
  input  logic [BYTE_W-1:0]   i_slot_byte,
  output logic [2:0]          o_grant_id,
  output logic                o_busy,
  output logic                o_timeout
);

  localparam logic [BYTE_W-1:0] MinBudget = BYTE_W'(MAX_PKT_BYTE);

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   budget_q, budget_d, given_q, given_d;
  logic [BYTE_W-1:0]   budget_sum, given_sum, byte_q;
  logic [IdW-1:0]      grant_id_q, rr_ptr_q, arb_idx;
  logic [PORT_NUM-1:0] resp_q, byte_valid_q, fin_prev_q, grant_oh, fin_rise;
  logic                busy_q, timeout_q, arb_valid, fin_hit, tmo_hit;

  forward_rr_arbiter #(
    .PORT_NUM(PORT_NUM)
  ) u_arb (
    .req_i  (i_forward_req),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (),
    .idx_o  (arb_idx),
    .valid_o(arb_valid)
  );

  assign grant_oh = PORT_NUM'(1) << grant_id_q;
  assign fin_rise = i_forward_finish & ~fin_prev_q;
  assign fin_hit  = (state_q == StWaitFin) && |(fin_rise & grant_oh);

`ifdef FORWARD_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q != StWaitFin) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  // A finish edge in the same cycle wins: that is a normal release, not a timeout.
  assign tmo_hit = (state_q == StWaitFin) && !fin_hit && (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (arb_valid && (budget_q >= MinBudget)) state_d = StResp;
      StResp:    state_d = StBudget;
      StBudget:  state_d = StWaitFin;
      StWaitFin: if (fin_hit || tmo_hit) state_d = StRelease;
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Budget handed over in BUDGET; increments arriving while waiting extend the live grant only.
  always_comb begin
    budget_sum = BYTE_W'(sat_add(64'(budget_q), 64'(i_slot_byte), BYTE_W));
    given_sum  = BYTE_W'(sat_add(64'(given_q), 64'(i_slot_byte), BYTE_W));
    budget_d   = budget_q;
    given_d    = given_q;
    case (state_q)
      StBudget: begin
        budget_d = i_slot_valid ? i_slot_byte : '0;
        given_d  = budget_q;
      end
      StWaitFin: if (i_slot_valid) given_d = given_sum;
      StRelease: begin
        given_d = '0;
        if (i_slot_valid) budget_d = budget_sum;
      end
      default: if (i_slot_valid) budget_d = budget_sum;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= StIdle;
      budget_q     <= '0;
      given_q      <= '0;
      byte_q       <= '0;
      grant_id_q   <= '0;
      rr_ptr_q     <= '0;
      resp_q       <= '0;
      byte_valid_q <= '0;
      fin_prev_q   <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      budget_q     <= budget_d;
      given_q      <= given_d;
      fin_prev_q   <= i_forward_finish;
      busy_q       <= (state_d != StIdle);
      timeout_q    <= tmo_hit;
      resp_q       <= '0;
      byte_valid_q <= '0;
      if ((state_q == StIdle) && (state_d == StResp)) begin
        grant_id_q <= arb_idx;
      end
      if (state_q == StResp) begin
        resp_q <= grant_oh;
      end
      if (state_q == StBudget) begin
        byte_q       <= budget_q;
        byte_valid_q <= grant_oh;
      end
      if ((state_q == StWaitFin) && i_slot_valid) begin
        byte_q       <= given_sum;
        byte_valid_q <= grant_oh;
      end
      if (state_q == StRelease) begin
        rr_ptr_q <= (grant_id_q == IdW'(PORT_NUM - 1)) ? '0 : grant_id_q + 3'd1;
      end
    end
  end

  assign o_forward_resp       = resp_q;
  assign o_forward_byte       = byte_q;
  assign o_forward_byte_valid = byte_valid_q;
  assign o_grant_id           = grant_id_q;
  assign o_busy               = busy_q;
  assign o_timeout            = timeout_q;

endmodule

// File: tb/tb_forward_grant_ctrl.sv
// Self-checking bench for forward_grant_ctrl: vector table, corner sequences, randomized grants.
module tb_forward_grant_ctrl;

  localparam int unsigned Tmo = 100;
  localparam logic [31:0] MinB = 32'd1518;

  logic        clk, rst_n;
  logic [3:0]  req, finish, resp, bvalid;
  logic        slot_valid, busy, timeout;
  logic [31:0] slot_byte, fbyte;
  logic [2:0]  grant_id;

  int n_tests, n_fail;

  // Transaction-level reference state: pending budget and next round-robin start port.
  logic [31:0] m_budget;
  int unsigned m_ptr;

  forward_grant_ctrl #(
    .PORT_NUM    (4),
    .BYTE_W      (32),
    .MAX_PKT_BYTE(1518),
    .TIMEOUT_CYC (Tmo)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst_n),
    .i_forward_req       (req),
    .o_forward_resp      (resp),
    .i_forward_finish    (finish),
    .o_forward_byte      (fbyte),
    .o_forward_byte_valid(bvalid),
    .i_slot_valid        (slot_valid),
    .i_slot_byte         (slot_byte),
    .o_grant_id          (grant_id),
    .o_busy              (busy),
    .o_timeout           (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] slot;
    logic [31:0] extra;
    int unsigned exp_id;
    logic [31:0] exp_byte;
    logic [31:0] exp_cum;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic int unsigned rr_pick(input logic [3:0] mask, input int unsigned ptr);
    for (int k = 0; k < 4; k++) begin
      int unsigned p;
      p = (ptr + k) % 4;
      if (((mask >> p) & 4'd1) != 4'd0) return p;
    end
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_slot(input logic [31:0] b);
    slot_valid = 1'b1;
    slot_byte  = b;
    step();
    slot_valid = 1'b0;
    m_budget   = sat32(m_budget, b);
    check("timeout_idle_on_slot", timeout, 0);
  endtask

  task automatic grant_txn(input logic [3:0] mask, input logic [31:0] slot,
                           input logic [31:0] ex1, input logic [31:0] ex2,
                           input logic [31:0] carry, input bit noise, input bit use_tmo,
                           output int unsigned got_id, output logic [31:0] got_byte,
                           output logic [31:0] got_cum);
    int unsigned exp;
    logic [3:0]  oh;
    logic [31:0] given, e;
    if (slot != 0) add_slot(slot);
    exp = rr_pick(mask, m_ptr);
    oh  = 4'b0001 << exp;
    req = mask;
    step();
    check("busy_in_resp", busy, 1);
    check("resp_latency", resp, 0);
    step();
    got_id = 32'(grant_id);
    check("resp_onehot", resp, oh);
    check("grant_id", grant_id, exp);
    check("bvalid_before_budget", bvalid, 0);
    req = '0;
    if (carry != 0) begin
      slot_valid = 1'b1;
      slot_byte  = carry;
    end
    step();
    slot_valid = 1'b0;
    got_byte   = fbyte;
    got_cum    = fbyte;
    check("bvalid_first", bvalid, oh);
    check("byte_first", fbyte, m_budget);
    check("resp_one_cycle", resp, 0);
    given    = m_budget;
    m_budget = carry;
    for (int k = 0; k < 2; k++) begin
      e = (k == 0) ? ex1 : ex2;
      if (e != 0) begin
        slot_valid = 1'b1;
        slot_byte  = e;
        step();
        slot_valid = 1'b0;
        given      = sat32(given, e);
        got_cum    = fbyte;
        check("bvalid_cumulative", bvalid, oh);
        check("byte_cumulative", fbyte, given);
        step();
        check("bvalid_pulse", bvalid, 0);
      end
    end
    if (noise) begin
      finish = 4'b0001 << ((exp + 1) % 4);
      step();
      check("busy_other_finish", busy, 1);
      finish = '0;
      step();
      check("busy_other_finish2", busy, 1);
    end
    if (use_tmo) begin
      for (int c = 1; c < int'(Tmo); c++) begin
        step();
        check("timeout_early", timeout, 0);
      end
      step();
      check("timeout_pulse", timeout, 1);
      check("busy_release_tmo", busy, 1);
      step();
      check("timeout_one_cycle", timeout, 0);
      check("busy_fall_tmo", busy, 0);
    end else begin
      finish = oh;
      step();
      check("busy_release", busy, 1);
      check("timeout_idle", timeout, 0);
      step();
      check("busy_fall", busy, 0);
      finish = '0;
    end
    m_ptr = (exp + 1) % 4;
  endtask

  int unsigned g_id;
  logic [31:0] g_byte, g_cum, r_slot, r_e1, r_e2, r_carry;
  logic [3:0]  r_mask;
  bit          r_noise;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    m_budget   = '0;
    m_ptr      = 0;
    rst_n      = 1'b0;
    req        = '0;
    finish     = '0;
    slot_valid = 1'b0;
    slot_byte  = '0;

    vecs[0] = '{req: 4'b0001, slot: 32'd4000, extra: 32'd0,    exp_id: 0, exp_byte: 32'd4000,
                exp_cum: 32'd4000};
    vecs[1] = '{req: 4'b0111, slot: 32'd3000, extra: 32'd0,    exp_id: 1, exp_byte: 32'd3000,
                exp_cum: 32'd3000};
    vecs[2] = '{req: 4'b0111, slot: 32'd3000, extra: 32'd0,    exp_id: 2, exp_byte: 32'd3000,
                exp_cum: 32'd3000};
    vecs[3] = '{req: 4'b0111, slot: 32'd3000, extra: 32'd2000, exp_id: 0, exp_byte: 32'd3000,
                exp_cum: 32'd5000};
    vecs[4] = '{req: 4'b1000, slot: 32'd1518, extra: 32'd0,    exp_id: 3, exp_byte: 32'd1518,
                exp_cum: 32'd1518};
    vecs[5] = '{req: 4'b1010, slot: 32'd2000, extra: 32'd0,    exp_id: 1, exp_byte: 32'd2000,
                exp_cum: 32'd2000};
    vecs[6] = '{req: 4'b1011, slot: 32'd2500, extra: 32'd100,  exp_id: 3, exp_byte: 32'd2500,
                exp_cum: 32'd2600};

    #12;
    check("rst_resp", resp, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_byte", fbyte, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      grant_txn(vecs[i].req, vecs[i].slot, vecs[i].extra, 32'd0, 32'd0, 1'b0, 1'b0,
                g_id, g_byte, g_cum);
      check("vec_id", g_id, vecs[i].exp_id);
      check("vec_byte", g_byte, vecs[i].exp_byte);
      check("vec_cum", g_cum, vecs[i].exp_cum);
    end

    // Below-threshold budget holds off a pending request until topped up.
    req = 4'b0001;
    add_slot(32'd1000);
    for (int c = 0; c < 4; c++) begin
      step();
      check("no_grant_below_min", busy, 0);
      check("no_resp_below_min", resp, 0);
    end
    add_slot(32'd600);
    grant_txn(4'b0001, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, g_id, g_byte, g_cum);
    check("topped_up_byte", g_byte, 32'd1600);

    // Saturation of both pending budget and live cumulative value; slot during BUDGET carries.
    add_slot(32'hFFFF_FFF0);
    grant_txn(4'b0110, 32'h100, 32'h20, 32'd0, 32'd700, 1'b0, 1'b0, g_id, g_byte, g_cum);
    check("sat_byte", g_byte, 32'hFFFF_FFFF);
    check("sat_cum", g_cum, 32'hFFFF_FFFF);
    grant_txn(4'b0001, 32'd1000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, g_id, g_byte, g_cum);
    check("carry_byte", g_byte, 32'd1700);

    // Reset while waiting for finish, with the requester still holding its request.
    req = 4'b0100;
    add_slot(32'd3000);
    step();
    check("pre_rst_busy", busy, 1);
    step();
    check("pre_rst_resp", resp, 4'b0100);
    step();
    check("pre_rst_bvalid", bvalid, 4'b0100);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_grant_id", grant_id, 0);
    check("async_rst_byte", fbyte, 0);
    check("async_rst_bvalid", bvalid, 0);
    check("async_rst_resp", resp, 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_budget = '0;
    m_ptr    = 0;
    step();
    check("post_rst_idle", busy, 0);
    grant_txn(4'b0100, 32'd2000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, g_id, g_byte, g_cum);
    check("post_rst_id", g_id, 2);
    check("post_rst_byte", g_byte, 32'd2000);

    for (int it = 0; it < 30; it++) begin
      r_mask  = 4'($urandom_range(1, 15));
      r_slot  = $urandom_range(0, 4000);
      r_e1    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 5000)) : 32'd0;
      r_e2    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 5000)) : 32'd0;
      r_carry = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1517)) : 32'd0;
      r_noise = 1'($urandom_range(0, 1));
      if (sat32(m_budget, r_slot) < MinB) begin
        if (r_slot != 0) add_slot(r_slot);
        req = r_mask;
        for (int c = 0; c < 3; c++) begin
          step();
          check("rand_no_grant", busy, 0);
          check("rand_no_resp", resp, 0);
        end
        req = '0;
      end else begin
        grant_txn(r_mask, r_slot, r_e1, r_e2, r_carry, r_noise, 1'b0, g_id, g_byte, g_cum);
      end
    end

`ifdef FORWARD_TIMEOUT_EN
    if (m_budget != 0) begin
      grant_txn(4'b0011, 32'd3000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, g_id, g_byte, g_cum);
    end
    grant_txn(4'b0011, 32'd3000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, g_id, g_byte, g_cum);
    grant_txn(4'b0011, 32'd3000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, g_id, g_byte, g_cum);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
